// File: rtl/nrisc_pkg.sv
// nrisc_pkg: state codes, opcodes and instruction field helpers for the nRISC control unit
package nrisc_pkg;

    typedef logic [1:0] opcode_t;
    typedef logic [2:0] reg_t;

    localparam logic [2:0] S_INICIO  = 3'd0;
    localparam logic [2:0] S_BUSCA   = 3'd1;
    localparam logic [2:0] S_DECOD   = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_MEM     = 3'd4;
    localparam logic [2:0] S_ESCRITA = 3'd5;
    localparam logic [2:0] S_PARADO  = 3'd6;
    localparam logic [2:0] S_ERRO    = 3'd7;

    localparam opcode_t OP_ADD  = 2'b00;
    localparam opcode_t OP_SUB  = 2'b01;
    localparam opcode_t OP_LW   = 2'b10;
    localparam opcode_t OP_HALT = 2'b11;

    localparam int OP_HI = 7;
    localparam int OP_LO = 6;
    localparam int RA_HI = 5;
    localparam int RA_LO = 3;
    localparam int RB_HI = 2;
    localparam int RB_LO = 0;

    function automatic opcode_t campo_op(input logic [7:0] instr);
        return instr[OP_HI:OP_LO];
    endfunction

    function automatic reg_t campo_ra(input logic [7:0] instr);
        return instr[RA_HI:RA_LO];
    endfunction

    function automatic reg_t campo_rb(input logic [7:0] instr);
        return instr[RB_HI:RB_LO];
    endfunction

endpackage

// File: rtl/contador_espera.sv
// contador_espera: counts wait cycles and flags when the count has reached the limit
module contador_espera #(
    parameter int LIMITE = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic limpar,
    input  logic habilitar,
    output logic no_limite
);

    localparam int W = $clog2(LIMITE + 1);

    logic [W-1:0] cont_q, cont_d;

    // clear has priority; otherwise count one step per enabled cycle
    always_comb begin
        cont_d = limpar ? '0 : habilitar ? cont_q + W'(1) : cont_q;
    end

    // counter register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) cont_q <= '0;
        else       cont_q <= cont_d;
    end

    assign no_limite = (cont_q == W'(LIMITE));

endmodule

// File: rtl/unidade_controle.sv
// unidade_controle: multicycle Moore control FSM for the nRISC datapath with wait timeout
module unidade_controle
    import nrisc_pkg::*;
#(
    parameter int LIMITE_ESPERA = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] Instrucao,
    input  logic       InstrPronta,
    input  logic       MemPronta,
    output logic       BuscaInstr,
    output logic [2:0] RegLido1,
    output logic [2:0] RegLido2,
    output logic [2:0] RegEscrito,
    output logic       EscReg,
    output logic       LerMem,
    output logic       MemParaReg,
    output logic       EscPC,
    output logic [1:0] ULAOp,
    output logic       Parado,
    output logic       Erro,
    output logic [2:0] Estado
);

    logic [2:0] state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic       esperando, pronto, no_limite;

    // only BUSCA and MEM wait, each on its own ready input
    assign esperando = (state_q == S_BUSCA) || (state_q == S_MEM);
    assign pronto    = (state_q == S_BUSCA) ? InstrPronta : (state_q == S_MEM) ? MemPronta : 1'b0;

    contador_espera #(.LIMITE(LIMITE_ESPERA)) u_espera (
        .clock     (clock),
        .reset     (reset),
        .limpar    (!esperando || pronto),
        .habilitar (esperando && !pronto),
        .no_limite (no_limite)
    );

    // next state; ready wins over timeout in the limit cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INICIO:  state_d = S_BUSCA;
            S_BUSCA:   state_d = InstrPronta ? S_DECOD : no_limite ? S_ERRO : S_BUSCA;
            S_DECOD:   state_d = (campo_op(ir_q) == OP_HALT) ? S_PARADO :
                                 (campo_op(ir_q) == OP_LW)   ? S_MEM : S_EXEC;
            S_EXEC:    state_d = S_ESCRITA;
            S_MEM:     state_d = MemPronta ? S_ESCRITA : no_limite ? S_ERRO : S_MEM;
            S_ESCRITA: state_d = S_BUSCA;
            default:   state_d = state_q;
        endcase
    end

    // IR loads only when a fetch completes
    always_comb begin
        ir_d = (state_q == S_BUSCA && InstrPronta) ? Instrucao : ir_q;
    end

    // state and instruction registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_INICIO;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    assign Estado     = state_q;
    assign BuscaInstr = (state_q == S_BUSCA);
    assign EscPC      = (state_q == S_DECOD);
    assign LerMem     = (state_q == S_MEM);
    assign EscReg     = (state_q == S_ESCRITA);
    assign MemParaReg = (state_q == S_ESCRITA) && (campo_op(ir_q) == OP_LW);
    assign RegEscrito = (state_q == S_ESCRITA) ? campo_ra(ir_q) : 3'd0;
    assign RegLido1   = campo_ra(ir_q);
    assign RegLido2   = campo_rb(ir_q);
    assign ULAOp      = (state_q == S_EXEC) ? campo_op(ir_q) : 2'b00;
    assign Parado     = (state_q == S_PARADO) || (state_q == S_ERRO);
    assign Erro       = (state_q == S_ERRO);

endmodule

// File: tb/tb_unidade_controle.sv
// tb_unidade_controle: directed self-checking bench for the nRISC control unit
module tb_unidade_controle;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] instrucao;
    logic       instr_pronta;
    logic       mem_pronta;
    logic       busca_instr, esc_reg, ler_mem, mem_para_reg, esc_pc, parado, erro;
    logic [2:0] reg_lido1, reg_lido2, reg_escrito, estado;
    logic [1:0] ula_op;

    int errs   = 0;
    int checks = 0;

    unidade_controle #(.LIMITE_ESPERA(15)) dut (
        .clock       (clock),
        .reset       (reset),
        .Instrucao   (instrucao),
        .InstrPronta (instr_pronta),
        .MemPronta   (mem_pronta),
        .BuscaInstr  (busca_instr),
        .RegLido1    (reg_lido1),
        .RegLido2    (reg_lido2),
        .RegEscrito  (reg_escrito),
        .EscReg      (esc_reg),
        .LerMem      (ler_mem),
        .MemParaReg  (mem_para_reg),
        .EscPC       (esc_pc),
        .ULAOp       (ula_op),
        .Parado      (parado),
        .Erro        (erro),
        .Estado      (estado)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // reset, release, and land in the first BUSCA cycle
    task automatic restart();
        reset = 1'b1;
        instr_pronta = 1'b0;
        mem_pronta = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        instrucao = 8'h00;
        instr_pronta = 1'b0;
        mem_pronta = 1'b0;
        @(negedge clock);
        chk("rst_estado", {5'd0, estado}, 8'd0);
        chk("rst_outs", {busca_instr, esc_reg, ler_mem, mem_para_reg, esc_pc, parado, erro, 1'b0}, 8'd0);
        chk("rst_regs", {ula_op, reg_lido1, reg_escrito}, 8'd0);
        reset = 1'b0;
        #1 chk("inicio_estado", {5'd0, estado}, 8'd0);
        @(negedge clock);
        chk("busca_after_rst", {6'd0, estado == 3'd1, busca_instr}, 8'b11);

        // ADD r2, r5
        instrucao = 8'b00_010_101;
        instr_pronta = 1'b1;
        tick();
        instr_pronta = 1'b0;
        instrucao = 8'hFF;
        chk("add_decod", {5'd0, estado}, 8'd2);
        chk("add_escpc", {7'd0, esc_pc}, 8'd1);
        chk("add_rl1", {5'd0, reg_lido1}, 8'd2);
        chk("add_rl2", {5'd0, reg_lido2}, 8'd5);
        tick();
        chk("add_exec", {5'd0, estado}, 8'd3);
        chk("add_ulaop", {6'd0, ula_op}, 8'd0);
        chk("add_escpc_once", {7'd0, esc_pc}, 8'd0);
        tick();
        chk("add_escrita", {5'd0, estado}, 8'd5);
        chk("add_escreg", {6'd0, esc_reg, mem_para_reg}, 8'b10);
        chk("add_regesc", {5'd0, reg_escrito}, 8'd2);
        tick();
        chk("add_busca", {5'd0, estado}, 8'd1);
        chk("add_escreg_off", {4'd0, esc_reg, mem_para_reg, reg_escrito == 3'd0, busca_instr}, 8'b0011);

        // SUB r7, r0
        instrucao = 8'b01_111_000;
        instr_pronta = 1'b1;
        tick();
        instr_pronta = 1'b0;
        tick();
        chk("sub_exec", {5'd0, estado}, 8'd3);
        chk("sub_ulaop", {6'd0, ula_op}, 8'd1);
        tick();
        chk("sub_regesc", {5'd0, reg_escrito}, 8'd7);
        tick();

        // MemPronta outside MEM has no effect
        mem_pronta = 1'b1;
        tick();
        chk("mempronta_ignored", {5'd0, estado}, 8'd1);
        mem_pronta = 1'b0;

        // LW r3, (r1) with memory ready after 3 wait cycles
        instrucao = 8'b10_011_001;
        instr_pronta = 1'b1;
        tick();
        instr_pronta = 1'b0;
        chk("lw_decod", {5'd0, estado}, 8'd2);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("lw_mem%0d", i), {4'd0, estado == 3'd4, ler_mem, reg_lido2 == 3'd1, 1'b0}, 8'b1110);
            if (i == 3) mem_pronta = 1'b1;
            tick();
        end
        mem_pronta = 1'b0;
        chk("lw_escrita", {5'd0, estado}, 8'd5);
        chk("lw_flags", {5'd0, ler_mem, mem_para_reg, esc_reg}, 8'b011);
        chk("lw_regesc", {5'd0, reg_escrito}, 8'd3);
        tick();
        chk("lw_busca", {5'd0, estado}, 8'd1);

        // fetch timeout: 16 BUSCA cycles then ERRO
        restart();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("to_busca%0d", i), {5'd0, estado}, 8'd1);
            tick();
        end
        chk("to_erro", {5'd0, estado}, 8'd7);
        chk("to_flags", {6'd0, erro, parado}, 8'b11);
        instr_pronta = 1'b1;
        tick();
        chk("to_sticky", {5'd0, estado}, 8'd7);

        // ready in the limit cycle wins, then memory timeout
        restart();
        for (int i = 0; i < 15; i++) tick();
        chk("lim_busca", {5'd0, estado}, 8'd1);
        instrucao = 8'b10_000_100;
        instr_pronta = 1'b1;
        tick();
        instr_pronta = 1'b0;
        chk("lim_decod", {5'd0, estado}, 8'd2);
        tick();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("mto_mem%0d", i), {5'd0, estado}, 8'd4);
            tick();
        end
        chk("mto_erro", {5'd0, estado}, 8'd7);
        chk("mto_flags", {6'd0, erro, parado}, 8'b11);

        // HALT
        restart();
        instrucao = 8'b11_000_000;
        instr_pronta = 1'b1;
        tick();
        instr_pronta = 1'b0;
        chk("halt_decod", {5'd0, estado}, 8'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("halt_parado%0d", i), {5'd0, estado}, 8'd6);
            chk($sformatf("halt_flags%0d", i), {5'd0, parado, erro, esc_reg}, 8'b100);
        end

        // reset in the middle of ESCRITA
        restart();
        instrucao = 8'b00_110_001;
        instr_pronta = 1'b1;
        tick();
        instr_pronta = 1'b0;
        tick();
        tick();
        chk("mid_escrita", {6'd0, estado == 3'd5, esc_reg}, 8'b11);
        reset = 1'b1;
        #1;
        chk("mid_rst_escreg", {7'd0, esc_reg}, 8'd0);
        chk("mid_rst_estado", {5'd0, estado}, 8'd0);
        chk("mid_rst_regs", {reg_lido1, reg_escrito, busca_instr, esc_pc}, 8'd0);
        @(negedge clock);
        reset = 1'b0;
        #1 chk("mid_rel_estado", {6'd0, estado == 3'd0, esc_reg}, 8'b10);
        @(negedge clock);
        chk("mid_busca", {6'd0, busca_instr, esc_reg}, 8'b10);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
